// File: rtl/mantra_clock_monitor_if.sv
// Signal bundle between the mantra clock monitor and its neighbours.
//   clk_mon    : divided clocks from the divider network, one bit per domain
//   mon_en     : monitoring enable
//   err_clr    : single-cycle clear of the sticky error flags
//   locked     : per-domain frequency verified
//   all_locked : registered AND of locked
//   err_sticky : per-domain sticky error flags
//   irq        : error-event pulse
// master = the side that drives clk_mon/mon_en/err_clr; slave = the monitor.
interface mantra_clock_monitor_if #(
  parameter int N_CH = 6
);
  logic [N_CH-1:0] clk_mon;
  logic            mon_en;
  logic            err_clr;
  logic [N_CH-1:0] locked;
  logic            all_locked;
  logic [N_CH-1:0] err_sticky;
  logic            irq;

  modport master (
    output clk_mon, mon_en, err_clr,
    input  locked, all_locked, err_sticky, irq
  );

  modport slave (
    input  clk_mon, mon_en, err_clr,
    output locked, all_locked, err_sticky, irq
  );
endinterface

// File: rtl/mantra_clock_monitor.sv
// Frequency/stuck monitor for the six Fibonacci-divided mantra clock domains
// (bindu, compute, l1, l2, l3, io). Everything runs on clk_master; each divided
// clock is sampled as data and the master-cycle interval between toggles is
// compared against the expected divide value.
// Ports:
//   clk_master : monitor clock, clocks every flop
//   rst_n      : asynchronous active-low reset
//   mon        : mantra_clock_monitor_if.slave (clk_mon, mon_en, err_clr in;
//                locked, all_locked, err_sticky, irq out)
// Build option:
//   MANTRA_MON_IRQ_EN defined   -> irq is a registered pulse the cycle after any
//                                  error event
//   MANTRA_MON_IRQ_EN undefined -> irq tied to 0, no irq flop
//
// Per-channel FSM
//   state  | meaning
//   IDLE   | waiting for a reference edge (after reset, disable or stuck input)
//   MEAS   | measuring intervals, counting consecutive good ones
//   LOCK   | LOCK_CNT good intervals seen, frequency verified
module mantra_clock_monitor #(
  parameter int N_CH     = 6,
  parameter int CNT_W    = 8,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic                  clk_master,
  input  logic                  rst_n,
  mantra_clock_monitor_if.slave mon
);

  localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic int div_of(input int k);
    case (k)
      0:       return 8;
      1:       return 13;
      2:       return 21;
      3:       return 34;
      4:       return 55;
      default: return 89;
    endcase
  endfunction

  if (N_CH != 6) begin : g_nch_chk
    $error("mantra_clock_monitor: channel map is fixed at 6 domains");
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_width_chk
    localparam int LIM = div_of(k) + TOL + 1;
    if (LIM > CNT_MAX) begin : g_too_narrow
      $error("mantra_clock_monitor: CNT_W too small for channel stuck limit");
    end
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  logic [N_CH-1:0]   sync1_q, sync2_q, edge_q, edge_det;
  logic [N_CH-1:0]   err_q, err_evt, locked_w;
  logic              all_locked_q;
  state_t            state_q [N_CH];
  state_t            state_d [N_CH];
  logic [CNT_W-1:0]  cnt_q   [N_CH];
  logic [CNT_W-1:0]  cnt_d   [N_CH];
  logic [GOOD_W-1:0] good_q  [N_CH];
  logic [GOOD_W-1:0] good_d  [N_CH];

  // Both polarities of toggle count as edges, so a healthy channel measures DIV_k.
  assign edge_det = sync2_q ^ edge_q;

  always_comb begin
    logic [CNT_W-1:0] lo, hi, lim;
    logic             in_tol;
    err_evt = '0;
    lo      = '0;
    hi      = '0;
    lim     = '0;
    in_tol  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      good_d[k]  = good_q[k];
      lo     = CNT_W'(div_of(k) - TOL);
      hi     = CNT_W'(div_of(k) + TOL);
      lim    = CNT_W'(div_of(k) + TOL + 1);
      in_tol = (cnt_q[k] >= lo) && (cnt_q[k] <= hi);
      if (!mon.mon_en) begin
        state_d[k] = S_IDLE;
        cnt_d[k]   = '0;
        good_d[k]  = '0;
      end else begin
        case (state_q[k])
          S_IDLE: begin
            // Counter holds here, so after a stuck event it stays at the limit.
            if (edge_det[k]) begin
              cnt_d[k]   = CNT_W'(1);
              good_d[k]  = '0;
              state_d[k] = S_MEAS;
            end
          end
          S_MEAS, S_LOCK: begin
            if (edge_det[k]) begin
              cnt_d[k] = CNT_W'(1);
              if (!in_tol) begin
                err_evt[k] = 1'b1;
                good_d[k]  = '0;
                state_d[k] = S_MEAS;
              end else if (state_q[k] == S_MEAS) begin
                if (good_q[k] >= GOOD_W'(LOCK_CNT - 1)) begin
                  good_d[k]  = GOOD_W'(LOCK_CNT);
                  state_d[k] = S_LOCK;
                end else begin
                  good_d[k] = good_q[k] + 1'b1;
                end
              end
            end else if (cnt_q[k] >= lim) begin
              err_evt[k] = 1'b1;
              good_d[k]  = '0;
              state_d[k] = S_IDLE;
            end else if (cnt_q[k] != '1) begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
          default: state_d[k] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    locked_w = '0;
    for (int k = 0; k < N_CH; k++) begin
      locked_w[k] = (state_q[k] == S_LOCK);
    end
  end

  always_ff @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      edge_q       <= '0;
      err_q        <= '0;
      all_locked_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
        good_q[k]  <= '0;
      end
    end else begin
      sync1_q      <= mon.clk_mon;
      sync2_q      <= sync1_q;
      edge_q       <= sync2_q;
      // A new event beats a simultaneous clear.
      err_q        <= (err_q & ~{N_CH{mon.err_clr}}) | err_evt;
      all_locked_q <= &locked_w;
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        good_q[k]  <= good_d[k];
      end
    end
  end

  assign mon.locked     = locked_w;
  assign mon.all_locked = all_locked_q;
  assign mon.err_sticky = err_q;

`ifdef MANTRA_MON_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |err_evt;
  end
  assign mon.irq = irq_q;
`else
  assign mon.irq = 1'b0;
`endif

endmodule

// File: tb/tb_mantra_clock_monitor.sv
module tb_mantra_clock_monitor;
  localparam int N   = 6;
  localparam int TOL = 1;
  localparam int LCK = 4;
  localparam int DIV [0:5] = '{8, 13, 21, 34, 55, 89};
`ifdef MANTRA_MON_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mantra_clock_monitor_if #(.N_CH(N)) bus ();

  mantra_clock_monitor #(.N_CH(N), .CNT_W(8), .TOL(TOL), .LOCK_CNT(LCK)) dut (
    .clk_master (clk),
    .rst_n      (rst_n),
    .mon        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- stimulus: divider network emulation ----------------
  bit [N-1:0] hold = '0;
  int         tick [N];
  int         per  [N];
  int         q1   [$];   // overrides for the next ch1 toggle intervals

  initial begin
    bus.clk_mon = '0;
    for (int k = 0; k < N; k++) begin
      tick[k] = 0;
      per[k]  = DIV[k];
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!hold[k]) begin
          tick[k]++;
          if (tick[k] >= per[k]) begin
            bus.clk_mon[k] = ~bus.clk_mon[k];
            tick[k] = 0;
            if (k == 1 && q1.size() > 0) per[k] = q1.pop_front();
            else                         per[k] = DIV[k];
          end
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Timestamp based: an input toggle becomes visible to the checker 3 master
  // edges after it is sampled; the interval is the time between visible edges.
  int         m_now;
  bit [N-1:0] h1, h2, h3;
  bit [N-1:0] m_act, m_locked, m_err;
  bit         m_all, m_irq;
  int         m_last [N];
  int         m_good [N];

  task automatic model_clear();
    m_now = 0; h1 = '0; h2 = '0; h3 = '0;
    m_act = '0; m_locked = '0; m_err = '0; m_all = 1'b0; m_irq = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_last[k] = 0;
      m_good[k] = 0;
    end
  endtask

  task automatic model_step();
    bit [N-1:0] ev, evt, prev_locked;
    int iv;
    m_now++;
    ev = h2 ^ h3;
    h3 = h2; h2 = h1; h1 = bus.clk_mon;
    prev_locked = m_locked;
    evt = '0;
    for (int k = 0; k < N; k++) begin
      if (!bus.mon_en) begin
        m_act[k] = 1'b0; m_good[k] = 0; m_locked[k] = 1'b0;
      end else if (!m_act[k]) begin
        if (ev[k]) begin
          m_act[k] = 1'b1; m_last[k] = m_now; m_good[k] = 0;
        end
      end else if (ev[k]) begin
        iv = m_now - m_last[k];
        m_last[k] = m_now;
        if (iv >= DIV[k] - TOL && iv <= DIV[k] + TOL) begin
          if (m_good[k] < LCK) m_good[k]++;
          if (m_good[k] == LCK) m_locked[k] = 1'b1;
        end else begin
          evt[k] = 1'b1; m_good[k] = 0; m_locked[k] = 1'b0;
        end
      end else if (m_now - m_last[k] >= DIV[k] + TOL + 1) begin
        evt[k] = 1'b1; m_act[k] = 1'b0; m_good[k] = 0; m_locked[k] = 1'b0;
      end
    end
    m_err = (m_err & ~{N{bus.err_clr}}) | evt;
    m_all = &prev_locked;
    m_irq = IRQ_EN ? |evt : 1'b0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1)
        check("cycle", {bus.locked, bus.all_locked, bus.err_sticky, bus.irq},
              {m_locked, m_all, m_err, m_irq});
    end
  end

  // ---------------- directed sequence ----------------
  task automatic wait_lock(input bit [N-1:0] mask, input int bound, input string name);
    int i = 0;
    while (((bus.locked & mask) != mask) && i < bound) begin
      @(negedge clk);
      i++;
    end
    check(name, bus.locked & mask, mask);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    bus.mon_en  = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.locked, bus.all_locked, bus.err_sticky, bus.irq}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mon_en = 1'b1;

    // 1: initial lock
    wait_lock(6'h01, 43, "lock_ch0");
    wait_lock(6'h3f, 450, "lock_all");
    @(negedge clk);
    check("all_locked", bus.all_locked, 1);
    check("no_err_after_lock", bus.err_sticky, 0);

    // 2: ch0 stuck
    hold[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("stuck_err", bus.err_sticky, 6'h01);
    check("stuck_locked", bus.locked, 6'h3e);
    check("stuck_all_locked", bus.all_locked, 0);
    hold[0] = 1'b0;
    wait_lock(6'h3f, 100, "relock_ch0");

    // 3: ch1 jitter 12/14 then one 16-cycle interval
    q1 = '{12, 14, 12, 14, 12, 14};
    repeat (90) @(negedge clk);
    check("jitter_locked", bus.locked, 6'h3f);
    check("jitter_err", bus.err_sticky, 6'h01);
    q1.push_back(16);
    repeat (35) @(negedge clk);
    check("long_err", bus.err_sticky, 6'h03);
    check("long_locked", bus.locked, 6'h3d);
    wait_lock(6'h3f, 120, "relock_ch1");

    // 4: err_clr coincident with a ch2 stuck event
    hold[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_act[2] && (m_now - m_last[2] == DIV[2] + TOL)) found = 1'b1;
    end
    check("clr_align", found, 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("clr_vs_set", bus.err_sticky, 6'h04);
    hold[2] = 1'b0;
    wait_lock(6'h3f, 150, "relock_ch2");

    // 5: monitoring disabled for 20 cycles
    bus.mon_en = 1'b0;
    @(negedge clk);
    check("dis_locked", bus.locked, 0);
    check("dis_irq", bus.irq, 0);
    repeat (19) @(negedge clk);
    check("dis_err_kept", bus.err_sticky, 6'h04);
    bus.mon_en = 1'b1;
    wait_lock(6'h3f, 460, "relock_en");
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("lone_clr", bus.err_sticky, 0);

    // 6: asynchronous reset mid-measurement
    repeat (37) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_rst", {bus.locked, bus.all_locked, bus.err_sticky, bus.irq}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_lock(6'h3f, 460, "relock_rst");
    @(negedge clk);
    check("all_locked_rst", bus.all_locked, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
